// File: rtl/bcd_product_conv.sv
// bcd_product_conv: sequential double-dabble conversion of an 8-bit product to three BCD digits
module bcd_product_conv (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       range_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [19:0] sr, adj, sh;
  logic [2:0] cnt;
  logic flag, load;
  always_comb begin
    adj = sr;
    adj[19:16] = sr[19:16] >= 4'd5 ? sr[19:16] + 4'd3 : sr[19:16];
    adj[15:12] = sr[15:12] >= 4'd5 ? sr[15:12] + 4'd3 : sr[15:12];
    adj[11:8] = sr[11:8] >= 4'd5 ? sr[11:8] + 4'd3 : sr[11:8];
    sh = adj << 1;
    load = state != SHIFT && start;
    state_nx = state == SHIFT ? (cnt == 3'd7 ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      flag <= 1'b0;
      hund <= '0;
      tens <= '0;
      ones <= '0;
      range_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        sr <= {12'd0, bin};
        cnt <= '0;
        flag <= bin > 8'd81;
      end else if (state == SHIFT) begin
        sr <= sh;
        cnt <= cnt + 3'd1;
        // the final shift's result goes straight to the outputs in one write
        if (cnt == 3'd7) begin
          hund <= sh[19:16];
          tens <= sh[15:12];
          ones <= sh[11:8];
          range_err <= flag;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_product_conv.sv
// tb_bcd_product_conv: randomized scoreboard bench against a decimal reference model
module tb_bcd_product_conv;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] bin = '0;
  logic busy, done, range_err;
  logic [3:0] hund, tens, ones;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int due;
    int h, t, o, e;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int edge_n = 0;
  logic s_start = 1'b0;
  logic [7:0] s_bin = '0;

  bcd_product_conv dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .busy(busy), .done(done),
    .hund(hund), .tens(tens), .ones(ones), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  // capture what the DUT saw on each rising edge
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    s_start <= reset ? 1'b0 : start;
    s_bin <= bin;
  end

  initial begin
    int free_at, last_acc, n;
    exp_t x;
    free_at = 0;
    last_acc = -100;
    held = '{0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        free_at = 0;
        last_acc = -100;
        held = '{0, 0, 0, 0, 0};
        continue;
      end
      n = edge_n;
      if (s_start && n >= free_at) begin
        x.due = n + 8;
        x.h = s_bin / 100;
        x.t = (s_bin / 10) % 10;
        x.o = s_bin % 10;
        x.e = s_bin > 81 ? 1 : 0;
        q.push_back(x);
        free_at = n + 9;
        last_acc = n;
      end
      if (q.size() != 0 && q[0].due == n) held = q.pop_front();
      chk("busy", busy, (n >= last_acc && n <= last_acc + 7) ? 1 : 0);
      chk("done", done, (n == last_acc + 8) ? 1 : 0);
      chk("busy_done_excl", busy & done, 0);
      chk("hund", hund, held.h);
      chk("tens", tens, held.t);
      chk("ones", ones, held.o);
      chk("range_err", range_err, held.e);
    end
  end

  task automatic go(input logic [7:0] b);
    @(posedge clk);
    #1 start = 1'b1;
    bin = b;
    @(posedge clk);
    #1 start = 1'b0;
    bin = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digits", {hund, tens, ones}, 0);
    chk("rst_err", range_err, 0);
    go(8'd81);
    repeat (9) @(posedge clk);
    go(8'd255);
    repeat (9) @(posedge clk);
    go(8'd0);
    repeat (9) @(posedge clk);
    go(8'd45);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    bin = 8'd99;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 bin = 8'($urandom);
    end
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    bin = 8'd72;
    repeat (9) @(posedge clk);
    #1 bin = 8'd18;
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    go(8'd63);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_digits", {hund, tens, ones}, 0);
    chk("async_err", range_err, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    go(8'd9);
    repeat (9) @(posedge clk);
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++) begin
        go(8'(a * b));
        repeat (8) @(posedge clk);
      end
    repeat (300) begin
      @(posedge clk);
      #1 start = ($urandom % 4) == 0;
      bin = 8'($urandom);
    end
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
